// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the register-file arbiter
package regfile_pkg;

  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 4;
  localparam int NUM_REQ  = 3;

  localparam int REQ_WB  = 0;
  localparam int REQ_OPA = 1;
  localparam int REQ_OPB = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_rr_arb.sv
// rtl/regfile_rr_arb.sv - two-way round-robin pick between the operand requesters
module regfile_rr_arb (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] choice
);

  // fav_b = 0 favours requester 1, fav_b = 1 favours requester 2
  logic fav_b;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fav_b <= 1'b0;
    end else if (advance) begin
      fav_b <= ~fav_b;
    end
  end

  always_comb begin
    choice = 2'b00;
    if (valid[0] && (!fav_b || !valid[1])) begin
      choice = 2'b01;
    end else if (valid[1]) begin
      choice = 2'b10;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - three-requester register-file port arbiter with clear-on-reset
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter bit INIT_CLEAR   = 1'b1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ-1:0]             req_gf,
  input  logic [NUM_REQ-1:0][REG_W-1:0]  req_regnum,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]              rsp_data,
  output logic                           rf_enable,
  output logic                           rf_rwflag,
  output logic                           rf_gf_flag,
  output logic [REG_W-1:0]               rf_regnum,
  output logic [DATA_W-1:0]              rf_inp,
  input  logic [DATA_W-1:0]              rf_outp,
  output logic                           init_done
);

  localparam int SW = $clog2(STARVE_LIMIT + 2);

  state_t             state, next_state;
  logic [4:0]         init_cnt;
  logic [SW-1:0]      starve_cnt;
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         rr_choice;
  logic               any_op;
  logic               force_rr;

  assign any_op   = req_valid[REQ_OPA] | req_valid[REQ_OPB];
  assign force_rr = any_op && (starve_cnt == SW'(STARVE_LIMIT));

  regfile_rr_arb u_rr (
    .clk     (clk),
    .rstn    (rstn),
    .valid   (req_valid[REQ_OPB:REQ_OPA]),
    .advance (grant[REQ_OPA] | grant[REQ_OPB]),
    .choice  (rr_choice)
  );

  always_comb begin
    next_state = state;
    grant      = '0;
    rf_enable  = 1'b0;
    rf_rwflag  = 1'b0;
    rf_gf_flag = 1'b0;
    rf_regnum  = '0;
    rf_inp     = '0;
    case (state)
      ST_IDLE: next_state = INIT_CLEAR ? ST_INIT : ST_RUN;
      ST_INIT: begin
        rf_enable  = 1'b1;
        rf_rwflag  = 1'b1;
        rf_gf_flag = init_cnt[4];
        rf_regnum  = init_cnt[3:0];
        if (init_cnt == 5'd31) next_state = ST_RUN;
      end
      ST_RUN: begin
        // writeback wins unless an operand requester has waited STARVE_LIMIT grants
        if (req_valid[REQ_WB] && !force_rr) grant = 3'b001;
        else                                 grant = {rr_choice, 1'b0};
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant[i]) begin
            rf_enable  = 1'b1;
            rf_rwflag  = req_write[i];
            rf_gf_flag = req_gf[i];
            rf_regnum  = req_regnum[i];
            rf_inp     = req_wdata[i];
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      init_cnt   <= '0;
      starve_cnt <= '0;
      pend       <= '0;
    end else begin
      state <= next_state;
      if (state == ST_INIT) init_cnt <= init_cnt + 5'd1;
      if (grant[REQ_WB] && any_op) starve_cnt <= starve_cnt + SW'(1);
      else                         starve_cnt <= '0;
      pend <= grant & ~req_write;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = pend;
  assign rsp_data  = rstn ? rf_outp : '0;
  assign init_done = (state == ST_RUN);

endmodule
